// File: rtl/key_expansion_multi.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per clock, packed
// into 128-bit round keys strobed out with their round index.
module key_expansion_multi #(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_in_valid,
  output logic         key_ready,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   key_addr,
  output logic         key_valid,
  output logic         key_loaded,
  output logic         mode_err,
  output logic [3:0]   num_rounds
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which also maps 0 to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [7:0][31:0]  win_q, win_d;
  logic [2:0][31:0]  acc_q, acc_d;
  logic [5:0]        i_q, i_d;
  logic [2:0]        wrap_q, wrap_d, nkm1_q, nkm1_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [127:0]      kout_q, kout_d;
  logic [3:0]        kaddr_q, kaddr_d, nr_q, nr_d;
  logic              kvalid_q, kvalid_d, loaded_q, loaded_d, merr_q, merr_d;

  logic        legal, accept;
  logic [31:0] prev, sub_in, sub_out, wnew;

  assign key_ready  = (state_q != S_RUN);
  assign legal      = (key_size == 2'b00) || (key_size == 2'b01 && SUPPORT_192) ||
                      (key_size == 2'b10 && SUPPORT_256);
  assign accept     = key_in_valid && key_ready && legal;

  // Window holds w[i-Nk] at slot 0 and w[i-1] at slot Nk-1; one SubWord serves both cases.
  assign prev    = win_q[nkm1_q];
  assign sub_in  = (wrap_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                    sbox(sub_in[15:8]),  sbox(sub_in[7:0])};

  always_comb begin
    if (i_q <= {3'b000, nkm1_q})              wnew = win_q[0];
    else if (wrap_q == 3'd0)                  wnew = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
    else if (nkm1_q == 3'd7 && wrap_q == 3'd4) wnew = win_q[0] ^ sub_out;
    else                                      wnew = win_q[0] ^ prev;
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    acc_d    = acc_q;
    i_d      = i_q;
    wrap_d   = wrap_q;
    nkm1_d   = nkm1_q;
    rcon_d   = rcon_q;
    kout_d   = kout_q;
    kaddr_d  = kaddr_q;
    nr_d     = nr_q;
    loaded_d = loaded_q;
    kvalid_d = 1'b0;
    merr_d   = key_in_valid && key_ready && !legal;
    if (accept) begin
      for (int j = 0; j < 8; j++) win_d[j] = key_in[255-32*j -: 32];
      case (key_size)
        2'b00:   nkm1_d = 3'd3;
        2'b01:   nkm1_d = 3'd5;
        default: nkm1_d = 3'd7;
      endcase
      nr_d     = {1'b0, nkm1_d} + 4'd7;
      i_d      = 6'd0;
      wrap_d   = 3'd0;
      rcon_d   = 8'h01;
      loaded_d = 1'b0;
      state_d  = S_RUN;
    end else if (state_q == S_RUN) begin
      for (int j = 0; j < 7; j++) win_d[j] = win_q[j+1];
      win_d[nkm1_q] = wnew;
      if (i_q > {3'b000, nkm1_q} && wrap_q == 3'd0)
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      wrap_d = (wrap_q == nkm1_q) ? 3'd0 : wrap_q + 3'd1;
      i_d    = i_q + 6'd1;
      if (i_q[1:0] == 2'b11) begin
        kout_d   = {acc_q[0], acc_q[1], acc_q[2], wnew};
        kaddr_d  = i_q[5:2];
        kvalid_d = 1'b1;
      end else begin
        acc_d[i_q[1:0]] = wnew;
      end
      if (i_q == {nr_q, 2'b11}) begin
        state_d  = S_DONE;
        loaded_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      wrap_q   <= '0;
      nkm1_q   <= '0;
      rcon_q   <= '0;
      kout_q   <= '0;
      kaddr_q  <= '0;
      nr_q     <= '0;
      kvalid_q <= 1'b0;
      loaded_q <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      wrap_q   <= wrap_d;
      nkm1_q   <= nkm1_d;
      rcon_q   <= rcon_d;
      kout_q   <= kout_d;
      kaddr_q  <= kaddr_d;
      nr_q     <= nr_d;
      kvalid_q <= kvalid_d;
      loaded_q <= loaded_d;
      merr_q   <= merr_d;
    end
  end

  assign key_out    = kout_q;
  assign key_addr   = kaddr_q;
  assign key_valid  = kvalid_q;
  assign key_loaded = loaded_q;
  assign mode_err   = merr_q;
  assign num_rounds = nr_q;
endmodule

// File: tb/tb_key_expansion_multi.sv
// Scoreboard bench for key_expansion_multi: reference key expansion with a
// log/antilog-built S-box, plus FIPS-197 anchor words.
module tb_key_expansion_multi;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         kiv, kiv2;
  logic [1:0]   ksz, ksz2;
  logic [255:0] kin;
  logic         key_ready, key_valid, key_loaded, mode_err;
  logic [127:0] key_out;
  logic [3:0]   key_addr, num_rounds;
  logic         kr2, kv2, kl2, me2;
  logic [127:0] ko2;
  logic [3:0]   ka2, nr2;

  key_expansion_multi dut (
    .clk(clk), .rst(rst), .key_in_valid(kiv), .key_ready(key_ready),
    .key_size(ksz), .key_in(kin), .key_out(key_out), .key_addr(key_addr),
    .key_valid(key_valid), .key_loaded(key_loaded), .mode_err(mode_err),
    .num_rounds(num_rounds));

  key_expansion_multi #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) dut_n256 (
    .clk(clk), .rst(rst), .key_in_valid(kiv2), .key_ready(kr2),
    .key_size(ksz2), .key_in(kin), .key_out(ko2), .key_addr(ka2),
    .key_valid(kv2), .key_loaded(kl2), .mode_err(me2), .num_rounds(nr2));

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    logic [3:0]   addr;
    logic [127:0] key;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0, n_err = 0, cyc = 0, strobe_cnt = 0;
  logic [127:0] got_key [0:14];
  logic [7:0]   sb_tab [0:255];
  logic [31:0]  mw [0:59];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is matched against the next expected round key, including its cycle.
  always @(negedge clk) begin
    if (!rst && key_valid) begin
      strobe_cnt++;
      if (sb.size() == 0) chk("spurious_kv", 128'(key_valid), 128'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("addr", 128'(key_addr), 128'(e.addr));
        chk("key", key_out, e.key);
        chk("cyc", 128'(cyc), 128'(e.cyc));
        if (key_addr <= 4'd14) got_key[key_addr] = key_out;
      end
    end
  end

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb_tab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_tab[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*nk + 28; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic load(input logic [255:0] k, input logic [1:0] sz);
    int   nk;
    exp_t e;
    nk = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 6 : 8;
    @(negedge clk);
    model_expand(k, nk);
    for (int r = 0; r < nk + 7; r++) begin
      e.addr = 4'(r);
      e.key  = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      e.cyc  = cyc + 1 + 4*r + 4;
      sb.push_back(e);
    end
    strobe_cnt = 0;
    kiv = 1'b1; kin = k; ksz = sz;
    @(negedge clk);
    kiv = 1'b0; kin = ~k; ksz = 2'b00;
    chk("loaded_clr", 128'(key_loaded), 128'(0));
    chk("ready_run", 128'(key_ready), 128'(0));
    chk("nr", 128'(num_rounds), 128'(nk + 6));
  endtask

  task automatic wait_done(input int exp_n);
    int t;
    t = 0;
    while (!key_loaded && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_to", 128'(key_loaded), 128'(1));
    @(negedge clk);
    chk("n_strobes", 128'(strobe_cnt), 128'(exp_n));
    chk("sb_empty", 128'(sb.size()), 128'(0));
    chk("ready_done", 128'(key_ready), 128'(1));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_kout"}, key_out, 128'(0));
    chk({tag, "_kaddr"}, 128'(key_addr), 128'(0));
    chk({tag, "_kvalid"}, 128'(key_valid), 128'(0));
    chk({tag, "_loaded"}, 128'(key_loaded), 128'(0));
    chk({tag, "_merr"}, 128'(mode_err), 128'(0));
    chk({tag, "_nr"}, 128'(num_rounds), 128'(0));
  endtask

  task automatic bad_mode(input string tag, input logic exp_loaded);
    @(negedge clk);
    kiv = 1'b1; ksz = 2'b11; kin = K256;
    @(negedge clk);
    kiv = 1'b0; ksz = 2'b00;
    chk({tag, "_merr"}, 128'(mode_err), 128'(1));
    chk({tag, "_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_loaded"}, 128'(key_loaded), 128'(exp_loaded));
    @(negedge clk);
    chk({tag, "_merr_clr"}, 128'(mode_err), 128'(0));
  endtask

  initial begin
    int t;
    kiv = 1'b0; kiv2 = 1'b0; ksz = 2'b00; ksz2 = 2'b00; kin = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    reset_chk("rst");
    rst = 1'b0;

    bad_mode("bad_idle", 1'b0);
    chk("bad_idle_nr", 128'(num_rounds), 128'(0));

    // 256-bit size on a build without AES-256 support
    @(negedge clk);
    kiv2 = 1'b1; ksz2 = 2'b10;
    @(negedge clk);
    kiv2 = 1'b0; ksz2 = 2'b00;
    chk("n256_merr", 128'(me2), 128'(1));
    chk("n256_ready", 128'(kr2), 128'(1));
    chk("n256_nr", 128'(nr2), 128'(0));
    repeat (6) begin
      @(negedge clk);
      chk("n256_kv", 128'(kv2), 128'(0));
    end
    kiv2 = 1'b1; ksz2 = 2'b00;
    @(negedge clk);
    kiv2 = 1'b0;
    chk("n256_acc128", 128'(nr2), 128'(10));

    load(K128, 2'b00);
    wait_done(11);
    chk("a128_r0", got_key[0], K128[255:128]);
    chk("a128_w4", 128'(got_key[1][127:96]), 128'(32'ha0fafe17));
    chk("a128_r10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("a128_nr", 128'(num_rounds), 128'(10));

    bad_mode("bad_done", 1'b1);

    load(K192, 2'b01);
    wait_done(13);
    chk("a192_w6", 128'(got_key[1][63:32]), 128'(32'hfe0c91f7));
    chk("a192_last", 128'(got_key[12][31:0]), 128'(32'h01002202));
    chk("a192_nr", 128'(num_rounds), 128'(12));

    // Key offers during RUN must be ignored silently
    load(K256, 2'b10);
    repeat (3) @(negedge clk);
    kiv = 1'b1; kin = K128; ksz = 2'b00;
    @(negedge clk);
    chk("run_ign_merr", 128'(mode_err), 128'(0));
    ksz = 2'b11;
    @(negedge clk);
    kiv = 1'b0; ksz = 2'b00;
    chk("run_ign_merr2", 128'(mode_err), 128'(0));
    wait_done(15);
    chk("a256_w8", 128'(got_key[2][127:96]), 128'(32'h9ba35411));
    chk("a256_last", 128'(got_key[14][31:0]), 128'(32'h706c631e));
    chk("a256_nr", 128'(num_rounds), 128'(14));

    load(K192, 2'b01);
    wait_done(13);

    // Reset mid-schedule after the round-3 strobe
    load(K128, 2'b00);
    t = 0;
    while (strobe_cnt < 4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_strobes", 128'(strobe_cnt), 128'(4));
    rst = 1'b1;
    sb.delete();
    #1;
    reset_chk("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    strobe_cnt = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", 128'(strobe_cnt), 128'(0));
    load(K128, 2'b00);
    wait_done(11);
    chk("reload_w4", 128'(got_key[1][127:96]), 128'(32'ha0fafe17));
    chk("reload_r10", got_key[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
